// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator: pixel-tick divider, h/v scan counters,
// zero-skew registered syncs and a one-clk frame-start pulse.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned HD      = 640,
    parameter int unsigned HF      = 16,
    parameter int unsigned HR      = 96,
    parameter int unsigned HB      = 48,
    parameter int unsigned VD      = 480,
    parameter int unsigned VF      = 10,
    parameter int unsigned VR      = 2,
    parameter int unsigned VB      = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start
);

    localparam int unsigned CW    = 10;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [CW-1:0]    H_END    = CW'(HD + HF + HR + HB - 1);
    localparam logic [CW-1:0]    V_END    = CW'(VD + VF + VR + VB - 1);
    localparam logic [CW-1:0]    H_DISP   = CW'(HD);
    localparam logic [CW-1:0]    V_DISP   = CW'(VD);
    localparam logic [CW-1:0]    H_SYNC_S = CW'(HD + HF);
    localparam logic [CW-1:0]    H_SYNC_E = CW'(HD + HF + HR - 1);
    localparam logic [CW-1:0]    V_SYNC_S = CW'(VD + VF);
    localparam logic [CW-1:0]    V_SYNC_E = CW'(VD + VF + VR - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CW-1:0]    h_q, h_d, v_q, v_d;
    logic             h_wrap, v_wrap;
    logic             hsync_d, vsync_d, frame_start_d;

    // Tick and video window decode straight from the registered state
    assign p_tick   = (div_q == DIV_MAX);
    assign video_on = (h_q < H_DISP) && (v_q < V_DISP);
    assign pixel_x  = h_q;
    assign pixel_y  = v_q;

    // Next-state: ">=" so any out-of-range count wraps to 0 on its next advance
    always_comb begin
        div_d         = (div_q >= DIV_MAX) ? '0 : div_q + DIV_W'(1);
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = 1'b0;
        h_wrap        = (h_q >= H_END);
        v_wrap        = (v_q >= V_END);
        if (p_tick) begin
            h_d = h_wrap ? '0 : h_q + CW'(1);
            if (h_wrap) begin
                v_d           = v_wrap ? '0 : v_q + CW'(1);
                frame_start_d = v_wrap;
            end
        end
        // Syncs decoded from next-state counts so they move with pixel_x/pixel_y
        hsync_d = !((h_d >= H_SYNC_S) && (h_d <= H_SYNC_E));
        vsync_d = !((v_d >= V_SYNC_S) && (v_d <= V_SYNC_E));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_q       <= div_d;
            h_q         <= h_d;
            v_q         <= v_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator for the 640x480 @ 60 Hz VGA controller. Sits directly upstream of the text/character data generator and the font-ROM path.
- Divides the system clock down to a pixel-rate tick and runs horizontal and vertical scan counters.
- Outputs the current pixel_x / pixel_y, active-low hsync / vsync, video_on and a frame-start pulse.
- The downstream data generator consumes pixel_x[9:0] and pixel_y[4:0] to form font-ROM addresses. The RGB output stage gates colour with video_on.

Parameters:
- CLK_DIV, 4: system clocks per pixel tick (100 MHz -> 25 MHz). Minimum 2.
- HD, 640: horizontal display pixels.
- HF, 16: horizontal front porch.
- HR, 96: horizontal retrace (sync pulse width).
- HB, 48: horizontal back porch.
- VD, 480: vertical display lines.
- VF, 10: vertical front porch.
- VR, 2: vertical retrace.
- VB, 33: vertical back porch.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- video_on  out  1  high while (pixel_x, pixel_y) is inside the visible area.
- p_tick  out  1  one-clk pulse per pixel period.
- pixel_x  out  10  current horizontal count, 0..HD+HF+HR+HB-1 (0..799).
- pixel_y  out  10  current vertical count, 0..VD+VF+VR+VB-1 (0..524).
- frame_start  out  1  one-clk pulse marking the first pixel of a new frame.

Behaviour:
- Derived constants:
  - H_END = HD+HF+HR+HB-1 = 799.
  - V_END = VD+VF+VR+VB-1 = 524.
  - H_SYNC window = [HD+HF, HD+HF+HR-1] = [656, 751].
  - V_SYNC window = [VD+VF, VD+VF+VR-1] = [490, 491].
- Reset (reset=0, asynchronous, effective immediately, no clk needed):
  - Divider counter = 0, h_count = 0, v_count = 0.
  - hsync = 1, vsync = 1, frame_start = 0, p_tick = 0.
  - video_on = 1, because counts are 0,0.
- Tick divider:
  - Counter of width clog2(CLK_DIV), incremented every clk, wraps CLK_DIV-1 -> 0.
  - p_tick = (div == CLK_DIV-1), decoded from the register.
  - First p_tick is the 4th clk after reset release (div 0,1,2,3). Period is exactly CLK_DIV clks.
- Horizontal counter:
  - On a clk edge with p_tick=1: h_count = (h_count == H_END) ? 0 : h_count+1.
  - Otherwise h_count holds.
- Vertical counter:
  - Advances only on an edge with p_tick=1 AND h_count == H_END.
  - v_count = (v_count == V_END) ? 0 : v_count+1.
  - Wraps simultaneously with h_count at end of frame.
- Outputs:
  - pixel_x = h_count; pixel_y = v_count. Both registered, change only on p_tick edges.
  - hsync and vsync are registered from the next-state counts, so they change on the same clk edge as the counts they correspond to (zero skew vs pixel_x/pixel_y).
  - hsync = 0 iff h_count is in H_SYNC window; vsync = 0 iff v_count is in V_SYNC window.
  - video_on = (h_count < HD) && (v_count < VD), combinational from registered counts.
- frame_start: registered. Asserted for exactly one clk on the edge where the counts wrap from (H_END, V_END) to (0,0). Not asserted at reset release.
- Timing totals:
  - Line = 800 ticks = 3200 clk.
  - Frame = 525 lines = 1,680,000 clk.
- Reset mid-frame: all state returns to reset values immediately. Counting restarts from (0,0) with divider 0. No partial sync pulse persists (hsync and vsync forced to 1).
- Counts never exceed H_END/V_END. Any out-of-range value (e.g. SEU) wraps to 0 at the next advance.

Test Plan:
- Reset: hold reset=0 for 5 clk, check all outputs at reset values. Release -> p_tick high on clk 4, 8, 12 …; pixel_x=1 after the first tick.
- Line wrap: run to pixel_x=799, pixel_y=0; on the next p_tick -> pixel_x=0, pixel_y=1, hsync=1.
- hsync window: pixel_x 655 -> hsync=1; 656..751 -> hsync=0; 752 -> hsync=1. Pulse width measured = 384 clk.
- video_on/vsync: at (639,479) video_on=1; at (640,479) and (0,480) video_on=0. vsync=0 only for lines 490..491, 6400 clk wide.
- Frame wrap: at (799,524) next tick -> (0,0), frame_start high for one clk. Consecutive frame_start pulses exactly 1,680,000 clk apart.
- Reset mid-frame: assert reset at (700,300) during hsync low -> immediately hsync=1, pixel_x=0, pixel_y=0. After release, timing identical to the cold-reset case.
